// File: rtl/dds_control_arbiter_if.sv
// -----------------------------------------------------------------------------
// dds_control_pkg / dds_control_arbiter_if
//
// Purpose : Shared DDS control word type, plus the bundle of signals between
//           the control sources, the arbiter and channelized_dds.
//
// dds_control_t fields:
//   valid         - word is meaningful this cycle (request / output strobe)
//   channel_index - target DDS channel (8 bits, wide enough to carry
//                   out-of-range indices that the arbiter must discard)
//   control_type  - operation to apply to the channel
//   setup_data    - {start[15:0], stop[15:0], step[15:0]} for sweeps
//   control_data  - free-form operation payload
//
// Interface signals:
//   Req_data     - per-requester control word (.valid is the request)
//   Req_ready    - per-requester accept strobe
//   Control_data - registered control word towards channelized_dds
//   Init_done    - post-reset channel clear sequence has completed
//   Drop_pulse   - one-cycle pulse when an accepted request was discarded
//
// Modports:
//   master - control-source side (drives Req_data)
//   slave  - arbiter side (drives everything else)
// -----------------------------------------------------------------------------
package dds_control_pkg;

   localparam int DDS_CH_W = 8;

   typedef enum logic [1:0] {
      dds_control_type_none        = 2'd0,
      dds_control_type_single_tone = 2'd1,
      dds_control_type_sin_sweep   = 2'd2,
      dds_control_type_fm          = 2'd3
   } dds_control_type_t;

   typedef struct packed {
      logic                valid;
      logic [DDS_CH_W-1:0] channel_index;
      dds_control_type_t   control_type;
      logic [47:0]         setup_data;
      logic [31:0]         control_data;
   } dds_control_t;

endpackage

interface dds_control_arbiter_if
   import dds_control_pkg::*;
#(
   parameter int NUM_REQUESTERS = 2
);

   dds_control_t              Req_data [NUM_REQUESTERS];
   logic [NUM_REQUESTERS-1:0] Req_ready;
   dds_control_t              Control_data;
   logic                      Init_done;
   logic                      Drop_pulse;

   modport master (
      output Req_data,
      input  Req_ready,
      input  Control_data,
      input  Init_done,
      input  Drop_pulse
   );

   modport slave (
      input  Req_data,
      output Req_ready,
      output Control_data,
      output Init_done,
      output Drop_pulse
   );

endinterface

// File: rtl/dds_control_arbiter.sv
// -----------------------------------------------------------------------------
// dds_control_arbiter
//
// Purpose : Shares the single channelized_dds control port between several
//           control sources. After reset it first walks every DDS channel
//           and writes a "none" word to each (clear sequence), then arbitrates
//           requesters round-robin, one transfer per cycle, registering the
//           granted word onto Control_data with one cycle of latency.
//           Requests addressing a channel that does not exist are accepted
//           (so the requester is not stalled) but discarded, flagged by a
//           one-cycle Drop_pulse.
//
// Ports:
//   Clk    - single clock, rising edge
//   Rst    - asynchronous, active-high reset
//   io_bus - dds_control_arbiter_if.slave:
//              Req_data[]   (in)  per-requester control words / requests
//              Req_ready[]  (out) per-requester accept strobe (combinational)
//              Control_data (out) registered control word
//              Init_done    (out) clear sequence complete
//              Drop_pulse   (out) accepted request discarded
// -----------------------------------------------------------------------------
module dds_control_arbiter
   import dds_control_pkg::*;
#(
   parameter int NUM_REQUESTERS      = 2,
   parameter int NUM_CHANNELS        = 16,
   parameter int CHANNEL_INDEX_WIDTH = $clog2(NUM_CHANNELS)
) (
   input  logic                  Clk,
   input  logic                  Rst,
   dds_control_arbiter_if.slave  io_bus
);

   localparam int PTR_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

   localparam logic [0:0] S_INIT = 1'b0;
   localparam logic [0:0] S_ARB  = 1'b1;

   localparam logic [CHANNEL_INDEX_WIDTH-1:0] LAST_CH  =
      CHANNEL_INDEX_WIDTH'(NUM_CHANNELS - 1);
   localparam logic [PTR_W-1:0]               LAST_REQ =
      PTR_W'(NUM_REQUESTERS - 1);

   // ---------------------------------------------------------------- state
   logic [0:0]                     r_state;
   logic [CHANNEL_INDEX_WIDTH-1:0] r_init_cnt;
   logic [PTR_W-1:0]               r_rr_ptr;
   dds_control_t                   r_ctrl;
   logic                           r_init_done;
   logic                           r_drop;

   // ---------------------------------------------------------------- wires
   logic [PTR_W-1:0] w_cand;
   logic             w_grant_any;
   logic [PTR_W-1:0] w_grant_idx;
   logic [PTR_W-1:0] w_next_ptr;
   dds_control_t     w_grant_word;
   dds_control_t     w_init_word;
   logic             w_out_of_range;

   // Round-robin search: scan requesters starting at r_rr_ptr, first valid
   // one wins. Only active once the clear sequence has finished.
   always_comb begin
      w_cand      = '0;
      w_grant_any = 1'b0;
      w_grant_idx = '0;
      if (r_state == S_ARB) begin
         for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
            w_cand = PTR_W'((32'(r_rr_ptr) + i) % 32'(NUM_REQUESTERS));
            if (!w_grant_any && io_bus.Req_data[w_cand].valid) begin
               w_grant_any = 1'b1;
               w_grant_idx = w_cand;
            end
         end
      end
   end

   // Ready is asserted only for the granted requester, which by construction
   // has valid high, so every ready pulse is a transfer.
   always_comb begin
      io_bus.Req_ready = '0;
      if (w_grant_any) begin
         io_bus.Req_ready[w_grant_idx] = 1'b1;
      end
   end

   always_comb begin
      w_grant_word       = io_bus.Req_data[w_grant_idx];
      w_grant_word.valid = 1'b1;
      w_out_of_range     =
         {{(32-DDS_CH_W){1'b0}}, w_grant_word.channel_index} >= 32'(NUM_CHANNELS);
      w_next_ptr         = (w_grant_idx == LAST_REQ) ? '0 : w_grant_idx + 1'b1;
   end

   always_comb begin
      w_init_word               = '0;
      w_init_word.valid         = 1'b1;
      w_init_word.channel_index = DDS_CH_W'(r_init_cnt);
      w_init_word.control_type  = dds_control_type_none;
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state     <= S_INIT;
         r_init_cnt  <= '0;
         r_rr_ptr    <= '0;
         r_ctrl      <= '0;
         r_init_done <= 1'b0;
         r_drop      <= 1'b0;
      end else begin
         // Output strobes default low; set below only when a word goes out.
         r_ctrl.valid <= 1'b0;
         r_drop       <= 1'b0;
         case (r_state)
            S_INIT: begin
               r_ctrl <= w_init_word;
               if (r_init_cnt == LAST_CH) begin
                  r_state     <= S_ARB;
                  r_init_done <= 1'b1;
               end else begin
                  r_init_cnt <= r_init_cnt + 1'b1;
               end
            end
            S_ARB: begin
               if (w_grant_any) begin
                  // Pointer advances identically for forwarded and dropped
                  // requests so a bad requester cannot starve the others.
                  r_rr_ptr <= w_next_ptr;
                  if (w_out_of_range) begin
                     r_drop <= 1'b1;
                  end else begin
                     r_ctrl <= w_grant_word;
                  end
               end
            end
            default: begin
               r_state <= S_INIT;
            end
         endcase
      end
   end

   assign io_bus.Control_data = r_ctrl;
   assign io_bus.Init_done    = r_init_done;
   assign io_bus.Drop_pulse   = r_drop;

endmodule

// File: doc/dds_control_arbiter.md
DDS_CONTROL_ARBITER -- requirements
Module: dds_control_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQUESTERS, default 2, number of control sources sharing the DDS control port.
REQ-002 SHALL have parameter NUM_CHANNELS, default 16, number of DDS channels.
REQ-003 SHALL have parameter CHANNEL_INDEX_WIDTH, default $clog2(NUM_CHANNELS), channel index width.
REQ-004 SHALL have port Clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port Rst, input, 1, reset, asynchronous and active-high.
REQ-006 SHALL have port Req_data, input, dds_control_t [NUM_REQUESTERS], per-requester control word; its .valid field is the request.
REQ-007 SHALL have port Req_ready, output, NUM_REQUESTERS, per-requester accept strobe.
REQ-008 SHALL have port Control_data, output, dds_control_t, registered control word to channelized_dds.
REQ-009 SHALL have port Init_done, output, 1, high once the post-reset channel clear sequence completes.
REQ-010 SHALL have port Drop_pulse, output, 1, one-cycle pulse when an accepted request was discarded.

Function
REQ-011 SHALL implement FSM states S_INIT and S_ARB, with S_INIT as the reset state.
REQ-012 SHALL, in S_INIT, issue one Control_data word per cycle to channel_index 0..NUM_CHANNELS-1 in ascending order.
REQ-013 SHALL give each S_INIT word control_type dds_control_type_none, setup_data zero and control_data zero.
REQ-014 SHALL hold every Req_ready bit low in S_INIT.
REQ-015 SHALL move from S_INIT to S_ARB on the cycle after the channel NUM_CHANNELS-1 word is issued.
REQ-016 SHALL set Init_done high in the same cycle as the S_INIT to S_ARB transition and keep it high until reset.
REQ-017 SHALL, in S_ARB, grant at most one requester per cycle by round-robin.
REQ-018 SHALL start the round-robin search at the index after the last granted requester; after reset the pointer is 0, so requester 0 has top priority.
REQ-019 SHALL drive Req_ready[i] combinationally high only when requester i is granted and Req_data[i].valid is 1.
REQ-020 SHALL treat a transfer as Req_data[i].valid and Req_ready[i] both high in the same cycle.
REQ-021 SHALL register the granted word onto Control_data with valid=1 on the next cycle (latency 1).
REQ-022 SHALL set Control_data.valid to 0 on any cycle with no transfer and no S_INIT word.
REQ-023 SHALL accept a request whose channel_index >= NUM_CHANNELS (Req_ready high) but discard it.
REQ-024 SHALL, for a discarded request, keep Control_data.valid 0 and pulse Drop_pulse one cycle later.
REQ-025 SHALL advance the round-robin pointer for a discarded request exactly as for a forwarded one.
REQ-026 SHALL sustain one transfer per cycle under continuous requests.
REQ-027 SHALL, when all requesters are valid continuously, grant each requester once per NUM_REQUESTERS cycles.
REQ-028 SHALL leave Req_ready low and the pointer unchanged when no requester is valid.
REQ-029 SHALL treat Req_data as stable while valid and not ready; a requester drops valid only after its transfer.

Reset
REQ-030 SHALL, on Rst assertion, immediately (asynchronously) force Control_data.valid 0, Req_ready all 0, Init_done 0, Drop_pulse 0, FSM S_INIT, init counter 0 and RR pointer 0.
REQ-031 SHALL, on Rst assertion mid S_INIT or mid S_ARB, abandon the in-flight word with no output.
REQ-032 SHALL restart the full clear sequence from channel 0 after Rst deassertion.
REQ-033 SHALL emit the first S_INIT word on the first rising edge after Rst deassertion.

Verification
REQ-034 SHALL be verified by: release reset, no requests -> Control_data valid for 16 consecutive cycles with channel_index 0..15 and type none, then Init_done=1.
REQ-035 SHALL be verified by: requester 0 valid during S_INIT -> Req_ready[0]=0 until Init_done; word out the cycle after the first S_ARB grant.
REQ-036 SHALL be verified by: both requesters valid continuously, 8 words each -> output alternates 0,1,0,1..., 16 consecutive valid cycles.
REQ-037 SHALL be verified by: requester 1 sends channel_index 20 (NUM_CHANNELS=16) -> Req_ready[1]=1, no Control_data.valid, Drop_pulse one cycle later.
REQ-038 SHALL be verified by: Rst asserted at S_INIT channel 7 -> outputs cleared at once; after release the sequence restarts at channel 0.
REQ-039 SHALL be verified by: sin_sweep word (channel 2, start -32767, stop 32767, step 10) via requester 1 -> identical fields on Control_data one cycle after transfer.
